// File: rtl/truth_table_sweeper.sv
// Clocked stimulus/capture stage for a combinational gate-under-test: drives every minterm,
// samples the gate, assembles the truth table and compares it. Optional macro: STOP_ON_MISMATCH_EN.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned T     = 1 << N_IN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [T-1:0]    expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [T-1:0]    table_out,
  output logic            match,
  output logic [N_IN-1:0] fail_index
);

  localparam int unsigned    W_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W_W-1:0] W_LAST = W_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] M_LAST = N_IN'(T - 1);

  if (SETTLE == 0 || N_IN == 0 || N_IN > 4) begin : g_bad_param
    $error("truth_table_sweeper: SETTLE must be >= 1 and N_IN in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] m_q, m_d;
  logic [W_W-1:0]  w_q, w_d;
  logic [T-1:0]    tbl_q, tbl_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            match_q, match_d;
  logic [N_IN-1:0] fidx_q, fidx_d;

  logic [T-1:0]    tbl_cap;
  logic [T-1:0]    diff;
  logic [N_IN-1:0] first_diff;
  logic            last_sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      w_q     <= '0;
      tbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      w_q     <= w_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      fidx_q  <= fidx_d;
    end
  end

  // Table as it will look after the current sample, and its lowest disagreeing minterm.
  always_comb begin
    tbl_cap       = tbl_q;
    tbl_cap[m_q]  = dut_out;
    diff          = tbl_cap ^ expected;
    first_diff    = '0;
    for (int i = int'(T) - 1; i >= 0; i--) begin
      if (diff[N_IN'(i)]) first_diff = N_IN'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    w_d         = w_q;
    tbl_d       = tbl_q;
    busy_d      = busy_q;
    done_d      = done_q;
    match_d     = match_q;
    fidx_d      = fidx_q;
    last_sample = (m_q == M_LAST);
`ifdef STOP_ON_MISMATCH_EN
    if (dut_out != expected[m_q]) last_sample = 1'b1;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          m_d     = '0;
          w_d     = '0;
          tbl_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          fidx_d  = '0;
        end
      end
      S_WAIT: begin
        if (w_q == W_LAST) state_d = S_SAMPLE;
        else               w_d     = w_q + W_W'(1);
      end
      S_SAMPLE: begin
        tbl_d = tbl_cap;
        if (last_sample) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (diff == '0);
          fidx_d  = first_diff;
`ifdef STOP_ON_MISMATCH_EN
          if (dut_out != expected[m_q]) begin
            match_d = 1'b0;
            fidx_d  = m_q;
          end
`endif
        end else begin
          state_d = S_WAIT;
          m_d     = m_q + N_IN'(1);
          w_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The minterm counter doubles as the registered gate stimulus.
  assign dut_in     = m_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = tbl_q;
  assign match      = match_q;
  assign fail_index = fidx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (2 inputs/settle 1, 3 inputs/settle 3)
// driving behavioural gates, with expected tables computed from the sweep rules.
module tb_truth_table_sweeper;

  localparam int unsigned NA = 2, SA = 1, TA = 4;
  localparam int unsigned NB = 3, SB = 3, TB = 8;

  typedef struct {
    logic [7:0] tbl;
    logic       match;
    logic [2:0] fidx;
    int         lat;
    int         k;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic          start_a = 1'b0;
  logic [TA-1:0] expected_a = '0;
  logic [TA-1:0] gate_a = '0;
  logic [NA-1:0] dut_in_a;
  logic          dut_out_a;
  logic          busy_a, done_a, match_a;
  logic [TA-1:0] table_out_a;
  logic [NA-1:0] fail_index_a;

  logic          start_b = 1'b0;
  logic [TB-1:0] expected_b = '0;
  logic [TB-1:0] gate_b = '0;
  logic [NB-1:0] dut_in_b;
  logic          dut_out_b;
  logic          busy_b, done_b, match_b;
  logic [TB-1:0] table_out_b;
  logic [NB-1:0] fail_index_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gates with a small propagation delay.
  assign #1 dut_out_a = gate_a[dut_in_a];
  assign #1 dut_out_b = gate_b[dut_in_b];

  truth_table_sweeper #(.N_IN(NA), .SETTLE(SA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .expected(expected_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
    .table_out(table_out_a), .match(match_a), .fail_index(fail_index_a)
  );

  truth_table_sweeper #(.N_IN(NB), .SETTLE(SB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .expected(expected_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
    .table_out(table_out_b), .match(match_b), .fail_index(fail_index_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a sweep captures the gate table; with early stop, only up to the first wrong minterm.
  function automatic exp_t model(input logic [7:0] g, input logic [7:0] e, input int t, input int s);
    exp_t r;
    int   stop_at;
    r.tbl   = '0;
    r.match = 1'b1;
    r.fidx  = '0;
    r.k     = 0;
    stop_at = t - 1;
    for (int i = t - 1; i >= 0; i--) begin
      if (g[i] != e[i]) begin
        r.match = 1'b0;
        r.fidx  = 3'(i);
      end
    end
`ifdef STOP_ON_MISMATCH_EN
    if (!r.match) stop_at = int'(r.fidx);
`endif
    for (int i = 0; i <= stop_at; i++) r.tbl[i] = g[i];
    r.lat = (s + 1) * (stop_at + 1);
    return r;
  endfunction

  // Monitors: pop and compare whenever a sweep completes.
  always @(negedge clk) begin
    exp_t it;
    if (done_a && !done_a_prev) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL A_unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        it = q_a.pop_front();
        chk("A_table", 32'(table_out_a), 32'(it.tbl));
        chk("A_match", 32'(match_a), 32'(it.match));
        chk("A_fail_index", 32'(fail_index_a), 32'(it.fidx));
        chk("A_latency", 32'(cyc - it.k), 32'(it.lat));
      end
    end
    done_a_prev = done_a;
  end

  always @(negedge clk) begin
    exp_t it;
    if (done_b && !done_b_prev) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL B_unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        it = q_b.pop_front();
        chk("B_table", 32'(table_out_b), 32'(it.tbl));
        chk("B_match", 32'(match_b), 32'(it.match));
        chk("B_fail_index", 32'(fail_index_b), 32'(it.fidx));
        chk("B_latency", 32'(cyc - it.k), 32'(it.lat));
      end
    end
    done_b_prev = done_b;
  end

  task automatic sweep_a(input logic [TA-1:0] g, input logic [TA-1:0] e);
    exp_t it;
    int   lat;
    @(negedge clk);
    gate_a     = g;
    expected_a = e;
    start_a    = 1'b1;
    it   = model(8'(g), 8'(e), TA, SA);
    it.k = cyc + 1;
    lat  = it.lat;
    q_a.push_back(it);
    @(negedge clk);
    start_a = 1'b0;
    for (int j = 0; j < lat; j++) begin
      chk("A_dut_in_step", 32'(dut_in_a), 32'(j / (SA + 1)));
      chk("A_busy", 32'(busy_a), 32'd1);
`ifndef STOP_ON_MISMATCH_EN
      expected_a = (j == lat - 1) ? e : TA'($urandom);
`endif
      @(negedge clk);
    end
    chk("A_dut_in_hold", 32'(dut_in_a), 32'(lat / (SA + 1) - 1));
    chk("A_busy_after", 32'(busy_a), 32'd0);
  endtask

  task automatic sweep_b(input logic [TB-1:0] g, input logic [TB-1:0] e);
    exp_t it;
    int   lat;
    @(negedge clk);
    gate_b     = g;
    expected_b = e;
    start_b    = 1'b1;
    it   = model(g, e, TB, SB);
    it.k = cyc + 1;
    lat  = it.lat;
    q_b.push_back(it);
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j < lat; j++) begin
      chk("B_dut_in_step", 32'(dut_in_b), 32'(j / (SB + 1)));
      @(negedge clk);
    end
    chk("B_busy_after", 32'(busy_b), 32'd0);
  endtask

  initial begin
    exp_t it;
    int   budget;
    logic [TA-1:0] g;
    logic [TA-1:0] e;
    logic [TB-1:0] gb;

    // Reset values, before and after clock edges.
    #1;
    chk("rst_A_dut_in", 32'(dut_in_a), 32'd0);
    chk("rst_A_busy", 32'(busy_a), 32'd0);
    chk("rst_A_done", 32'(done_a), 32'd0);
    chk("rst_A_match", 32'(match_a), 32'd0);
    chk("rst_A_table", 32'(table_out_a), 32'd0);
    chk("rst_A_fail_index", 32'(fail_index_a), 32'd0);
    chk("rst_B_table", 32'(table_out_b), 32'd0);
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_A_busy", 32'(busy_a), 32'd0);
    start_a = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_A_busy", 32'(busy_a), 32'd0);

    // Directed gates against an XOR expectation.
    sweep_a(4'b0110, 4'b0110);
    sweep_a(4'b0001, 4'b0110);
    sweep_a(4'b1000, 4'b0110);

    for (int n = 0; n < 20; n++) begin
      g = TA'($urandom);
      e = ($urandom_range(0, 1) == 1) ? g : TA'($urandom);
      sweep_a(g, e);
    end

    // Start held through a sweep: no restart while busy, restart on the edge after done.
    @(negedge clk);
    gate_a     = 4'b1110;
    expected_a = 4'b1110;
    start_a    = 1'b1;
    it   = model(8'(gate_a), 8'(expected_a), TA, SA);
    it.k = cyc + 1;
    q_a.push_back(it);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!done_a && budget < 40);
    chk("A_held_done_seen", 32'(done_a), 32'd1);
    it.k = cyc + 1;
    q_a.push_back(it);
    @(negedge clk);
    chk("A_held_done_drops", 32'(done_a), 32'd0);
    chk("A_held_restart_busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!done_a && budget < 40);
    chk("A_held_second_done", 32'(done_a), 32'd1);

    // Asynchronous reset during minterm 2 discards the partial sweep.
    @(negedge clk);
    gate_a     = 4'b0110;
    expected_a = 4'b0110;
    start_a    = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("A_pre_reset_dut_in", 32'(dut_in_a), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("A_async_dut_in", 32'(dut_in_a), 32'd0);
    chk("A_async_busy", 32'(busy_a), 32'd0);
    chk("A_async_table", 32'(table_out_a), 32'd0);
    chk("A_async_done", 32'(done_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("A_post_reset_idle_busy", 32'(busy_a), 32'd0);
      chk("A_post_reset_idle_done", 32'(done_a), 32'd0);
    end
    sweep_a(4'b0110, 4'b0110);

    // Three-input instance: XOR3 then random gates.
    sweep_b(8'b1001_0110, 8'b1001_0110);
    sweep_b(8'b1001_0110, 8'b1001_0111);
    for (int n = 0; n < 4; n++) begin
      gb = TB'($urandom);
      sweep_b(gb, ($urandom_range(0, 1) == 1) ? gb : TB'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("A_scoreboard_drained", 32'(q_a.size()), 32'd0);
    chk("B_scoreboard_drained", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage placed directly upstream and downstream of a combinational gate-under-test, such as the NOR-built XOR exercise cells.
- Drives every input minterm into the gate in ascending order, waits a settle interval, and samples the gate output.
- Assembles the sampled outputs into a truth-table word and compares it against an expected word.
- Replaces hand-written #delay stimulus lists with a reusable, clocked sweeper.

Parameters:
N_IN, 2, number of gate-under-test inputs (1..4); table width T = 2**N_IN
SETTLE, 1, clock cycles each minterm is held before sampling (>=1; 0 is illegal, elaboration error)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
expected  input  T  expected truth table; bit m = expected output for minterm m
dut_in  output  N_IN  vector driven to gate inputs; MSB = first listed input (a), LSB = last (b)
dut_out  input  1  gate-under-test output
busy  output  1  high while sweeping
done  output  1  high from sweep completion until the next accepted start
table_out  output  T  captured table; bit m = dut_out sampled for minterm m
match  output  1  table_out == expected; valid while done
fail_index  output  N_IN  lowest minterm with mismatch; valid while done && !match, else 0

Behaviour:
- Reset, asynchronous, reset_n low: state=IDLE, dut_in=0, busy=0, done=0, match=0, table_out=0, fail_index=0, internal minterm counter m=0, wait counter w=0. Outputs hold these values immediately, without waiting for clk.
- States and transitions:
  - IDLE: start=1 -> WAIT. Same edge sets m=0, dut_in=0, w=0, table_out=0, busy=1, done=0.
  - WAIT: if w==SETTLE-1 -> SAMPLE, else w<=w+1.
  - SAMPLE: table_out[m]<=dut_out.
    - If m==T-1 -> DONE.
    - Else m<=m+1, dut_in<=m+1, w<=0 -> WAIT.
  - DONE: busy=0, done=1, match and fail_index registered on entry. start=1 -> WAIT, with the same initialisation as from IDLE.
- Sampling point: dut_in is stable for SETTLE+1 edges before the sampling edge, so combinational gate delay is absorbed.
- Latency: with start sampled at edge k, done rises after edge k+(SETTLE+1)*T.
  - Example: N_IN=2, SETTLE=1 gives 8 edges.
- match/fail_index: computed from the final table, including the bit captured on the last SAMPLE edge.
  - fail_index is the lowest set bit of table_out^expected.
- start while busy: ignored. No restart, no effect on m.
- expected may change during a sweep. Only its value at the DONE-entry edge is used.
- dut_in after DONE holds T-1 until the next start.
- Wrap-around: m never exceeds T-1. The counter is N_IN bits wide and never increments past T-1.
- reset_n asserted mid-sweep: immediate return to the reset values above. The partial table is discarded.

Optional Feature:
STOP_ON_MISMATCH_EN
- Defined: in SAMPLE, if dut_out != expected[m], capture the bit, then go to DONE immediately.
  - match=0, fail_index=m.
  - Uncaptured table_out bits remain 0.
  - Total latency is (SETTLE+1)*(m+1).
- Undefined: the full sweep always runs, exactly as described in Behaviour.

Test Plan:
- XOR from NOR cells (a'^b'), N_IN=2, SETTLE=1, expected=4'b0110, start pulse -> dut_in steps 00,01,10,11 every 2 cycles; done after 8 edges; table_out=0110, match=1, fail_index=0.
- NOR gate attached, expected=4'b0110 -> table_out=0001, match=0, fail_index=0. With STOP_ON_MISMATCH_EN: done after 2 edges, table_out=0001, fail_index=0.
- AND gate, expected=4'b0110 -> table_out=1000, match=0, fail_index=1. With STOP_ON_MISMATCH_EN: done after 4 edges, table_out=0000 (bit 1 captured as 0), fail_index=1.
- start held high continuously through a sweep -> no restart while busy; a new sweep begins on the edge after done, and done drops that edge.
- reset_n pulled low asynchronously during minterm 2 (between edges) -> outputs zero at once; after release, state IDLE, start needed again; the next sweep produces the full correct table.
- SETTLE=3, N_IN=3, 3-input XOR, expected=8'b10010110 -> each dut_in value held 4 cycles; done after 32 edges; match=1.
